// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA counters, registered syncs and margins with frame-boundary shadowed timing config.
// Defining VGA_TIMING_PREFETCH_EN adds the registered Pix_req look-ahead output.
module vga_timing_gen #(
    parameter int   REZ_MAX_WIDTH = 11,
    parameter logic SYNC_ACTIVE   = 1'b0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Pix_en,
    input  logic [REZ_MAX_WIDTH-1:0] H_sync,
    input  logic [REZ_MAX_WIDTH-1:0] H_back,
    input  logic [REZ_MAX_WIDTH-1:0] H_active,
    input  logic [REZ_MAX_WIDTH-1:0] H_front,
    input  logic [REZ_MAX_WIDTH-1:0] V_sync,
    input  logic [REZ_MAX_WIDTH-1:0] V_back,
    input  logic [REZ_MAX_WIDTH-1:0] V_active,
    input  logic [REZ_MAX_WIDTH-1:0] V_front,
    output logic [REZ_MAX_WIDTH-1:0] Count_h,
    output logic [REZ_MAX_WIDTH-1:0] Count_v,
    output logic [REZ_MAX_WIDTH-1:0] H_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] H_right_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_right_margin,
    output logic                     HSync,
    output logic                     VSync,
    output logic                     Line_start,
    output logic                     Frame_start,
    output logic                     Cfg_err
`ifdef VGA_TIMING_PREFETCH_EN
    ,
    output logic                     Pix_req
`endif
);
    localparam int W = REZ_MAX_WIDTH;
    localparam int T = REZ_MAX_WIDTH + 2;
    localparam logic [T-1:0] MAX_TOT = {2'b00, {W{1'b1}}};

    logic [W-1:0] hs_q, hb_q, ha_q, hf_q, vs_q, vb_q, va_q, vf_q;
    logic [W-1:0] h_left, v_left, nh, nv;
    logic [T-1:0] cfg_htot, cfg_vtot, htot, vtot;
    logic         cfg_ok, wrap_h, wrap_v, load;

    always_comb begin
        cfg_htot = T'(H_sync) + T'(H_back) + T'(H_active) + T'(H_front);
        cfg_vtot = T'(V_sync) + T'(V_back) + T'(V_active) + T'(V_front);
        htot     = T'(hs_q) + T'(hb_q) + T'(ha_q) + T'(hf_q);
        vtot     = T'(vs_q) + T'(vb_q) + T'(va_q) + T'(vf_q);
        cfg_ok   = (|H_sync) && (|H_active) && (|V_sync) && (|V_active)
                   && (cfg_htot <= MAX_TOT) && (cfg_vtot <= MAX_TOT);
        // >= rather than == so a freshly shrunk total cannot let the counter run away
        wrap_h   = T'(Count_h) >= htot - T'(1);
        wrap_v   = T'(Count_v) >= vtot - T'(1);
        load     = Pix_en && wrap_h && wrap_v;
        h_left   = hs_q + hb_q;
        v_left   = vs_q + vb_q;
        nh       = wrap_h ? '0 : Count_h + W'(1);
        nv       = wrap_h ? (wrap_v ? '0 : Count_v + W'(1)) : Count_v;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            {hs_q, hb_q, ha_q, hf_q} <= cfg_ok ? {H_sync, H_back, H_active, H_front}
                                               : {W'(96), W'(48), W'(640), W'(16)};
            {vs_q, vb_q, va_q, vf_q} <= cfg_ok ? {V_sync, V_back, V_active, V_front}
                                               : {W'(2), W'(33), W'(480), W'(10)};
            Cfg_err        <= !cfg_ok;
            Count_h        <= '0;
            Count_v        <= '0;
            Line_start     <= 1'b0;
            Frame_start    <= 1'b0;
            HSync          <= ~SYNC_ACTIVE;
            VSync          <= ~SYNC_ACTIVE;
            H_left_margin  <= '0;
            H_right_margin <= '0;
            V_left_margin  <= '0;
            V_right_margin <= '0;
        end else begin
            Line_start     <= Pix_en && wrap_h;
            Frame_start    <= load;
            HSync          <= (Count_h < hs_q) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            VSync          <= (Count_v < vs_q) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            H_left_margin  <= h_left;
            H_right_margin <= h_left + ha_q - W'(1);
            V_left_margin  <= v_left;
            V_right_margin <= v_left + va_q - W'(1);
            if (Pix_en) begin
                Count_h <= nh;
                Count_v <= nv;
            end
            if (load && cfg_ok) begin
                {hs_q, hb_q, ha_q, hf_q} <= {H_sync, H_back, H_active, H_front};
                {vs_q, vb_q, va_q, vf_q} <= {V_sync, V_back, V_active, V_front};
            end
            if (load) Cfg_err <= !cfg_ok;
        end
    end

`ifdef VGA_TIMING_PREFETCH_EN
    always_ff @(posedge Clk) begin
        if (Rst) Pix_req <= 1'b0;
        else Pix_req <= (nh >= h_left) && (nh < h_left + ha_q) && (nv >= v_left) && (nv < v_left + va_q);
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen plus directed timing checks.
module tb_vga_timing_gen;
    localparam int W = 11;

    logic         Clk = 1'b0, Rst = 1'b1, Pix_en = 1'b1;
    logic [W-1:0] H_sync, H_back, H_active, H_front, V_sync, V_back, V_active, V_front;
    logic [W-1:0] Count_h, Count_v, H_left_margin, H_right_margin, V_left_margin, V_right_margin;
    logic         HSync, VSync, Line_start, Frame_start, Cfg_err;
`ifdef VGA_TIMING_PREFETCH_EN
    logic         Pix_req;
`endif

    int checks = 0, errors = 0;

    always #5 Clk = ~Clk;

    vga_timing_gen dut (
        .Clk(Clk), .Rst(Rst), .Pix_en(Pix_en),
        .H_sync(H_sync), .H_back(H_back), .H_active(H_active), .H_front(H_front),
        .V_sync(V_sync), .V_back(V_back), .V_active(V_active), .V_front(V_front),
        .Count_h(Count_h), .Count_v(Count_v),
        .H_left_margin(H_left_margin), .H_right_margin(H_right_margin),
        .V_left_margin(V_left_margin), .V_right_margin(V_right_margin),
        .HSync(HSync), .VSync(VSync), .Line_start(Line_start), .Frame_start(Frame_start),
        .Cfg_err(Cfg_err)
`ifdef VGA_TIMING_PREFETCH_EN
        , .Pix_req(Pix_req)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] h, v, hl, hr, vl, vr;
        logic         hs, vs, ls, fs, err;
    } exp_t;

    exp_t sb[$];
    exp_t m, e;
    int   sh[8], in_c[8];
    int   m_h = 0, m_v = 0, ht, vt;
    bit   wh, wv;

    function automatic bit cfg_valid(input int c[8]);
        return c[0] != 0 && c[2] != 0 && c[4] != 0 && c[6] != 0
               && c[0] + c[1] + c[2] + c[3] < 2048 && c[4] + c[5] + c[6] + c[7] < 2048;
    endfunction

    // reference model: predicts post-edge outputs and queues them
    initial forever begin
        @(posedge Clk);
        in_c = '{int'(H_sync), int'(H_back), int'(H_active), int'(H_front),
                 int'(V_sync), int'(V_back), int'(V_active), int'(V_front)};
        ht = sh[0] + sh[1] + sh[2] + sh[3];
        vt = sh[4] + sh[5] + sh[6] + sh[7];
        if (Rst) begin
            if (cfg_valid(in_c)) sh = in_c;
            else sh = '{96, 48, 640, 16, 2, 33, 480, 10};
            m.err = !cfg_valid(in_c);
            m_h = 0; m_v = 0;
            m.ls = 0; m.fs = 0; m.hs = 1; m.vs = 1;
            m.hl = 0; m.hr = 0; m.vl = 0; m.vr = 0;
        end else begin
            m.hs = !(m_h < sh[0]);
            m.vs = !(m_v < sh[4]);
            m.hl = W'(sh[0] + sh[1]);
            m.hr = W'(sh[0] + sh[1] + sh[2] - 1);
            m.vl = W'(sh[4] + sh[5]);
            m.vr = W'(sh[4] + sh[5] + sh[6] - 1);
            wh = m_h >= ht - 1;
            wv = m_v >= vt - 1;
            m.ls = Pix_en && wh;
            m.fs = Pix_en && wh && wv;
            if (Pix_en) begin
                m_h = wh ? 0 : m_h + 1;
                if (wh) m_v = wv ? 0 : m_v + 1;
                if (wh && wv) begin
                    if (cfg_valid(in_c)) sh = in_c;
                    m.err = !cfg_valid(in_c);
                end
            end
        end
        m.h = W'(m_h);
        m.v = W'(m_v);
        sb.push_back(m);
    end

    initial forever begin
        @(negedge Clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_count_h", Count_h, e.h);
            check("sb_count_v", Count_v, e.v);
            check("sb_h_left", H_left_margin, e.hl);
            check("sb_h_right", H_right_margin, e.hr);
            check("sb_v_left", V_left_margin, e.vl);
            check("sb_v_right", V_right_margin, e.vr);
            check("sb_hsync", HSync, e.hs);
            check("sb_vsync", VSync, e.vs);
            check("sb_line_start", Line_start, e.ls);
            check("sb_frame_start", Frame_start, e.fs);
            check("sb_cfg_err", Cfg_err, e.err);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_cfg(input int hs, hb, ha, hf, vs, vb, va, vf);
        {H_sync, H_back, H_active, H_front} = {W'(hs), W'(hb), W'(ha), W'(hf)};
        {V_sync, V_back, V_active, V_front} = {W'(vs), W'(vb), W'(va), W'(vf)};
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(2);
        Rst = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int exp_n);
        int n = 0;
        do begin
            step();
            n++;
        end while (!Frame_start && n < 20000);
        check(tag, n, exp_n);
    endtask

    int h0, lows, pulses;

    initial begin
        // 640x480@60: margins, line wrap, sync widths
        set_cfg(96, 48, 640, 16, 2, 33, 480, 10);
        Pix_en = 1'b1;
        Rst = 1'b1;
        step(2);
        check("rst_count_h", Count_h, 0);
        check("rst_hsync", HSync, 1);
        check("rst_h_left", H_left_margin, 0);
        Rst = 1'b0;
        step();
        check("h_left_640", H_left_margin, 144);
        check("h_right_640", H_right_margin, 783);
        check("v_left_640", V_left_margin, 35);
        check("v_right_640", V_right_margin, 514);
        step(798);
        check("count_h_799", Count_h, 799);
        step();
        check("count_h_wrap", Count_h, 0);
        check("line_start_800", Line_start, 1);
        check("count_v_1", Count_v, 1);
        lows = 0; pulses = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            lows += int'(HSync == 1'b0);
            pulses += int'(Line_start);
        end
        check("hsync_low_96", lows, 96);
        check("line_pulses_per_800", pulses, 1);
        check("line_start_1600", Line_start, 1);
        check("vsync_line1_low", VSync, 0);
        step();
        check("vsync_line2_high", VSync, 1);

        // short frames: frame wrap, deferred reconfiguration, config rejection
        set_cfg(96, 48, 640, 16, 1, 1, 2, 1);
        do_reset();
        wait_frame("frame_period_4000", 4000);
        check("frame_count_v_0", Count_v, 0);
        check("frame_line_start", Line_start, 1);
        check("v_left_small", V_left_margin, 2);
        check("v_right_small", V_right_margin, 3);
        step(100);
        H_active = W'(800);
        wait_frame("frame_old_timing", 3900);
        check("h_right_before_load", H_right_margin, 783);
        step();
        check("h_right_943", H_right_margin, 943);
        wait_frame("frame_period_4800", 4799);
        step(100);
        H_sync = '0;
        step();
        check("cfg_err_pending", Cfg_err, 0);
        wait_frame("frame_after_bad", 4699);
        check("cfg_err_set", Cfg_err, 1);
        step();
        check("h_right_kept", H_right_margin, 943);
        check("h_left_kept", H_left_margin, 144);
        step(99);
        H_sync = W'(96);
        wait_frame("frame_kept_4800", 4700);
        check("cfg_err_cleared", Cfg_err, 0);

        // pixel enable at half rate
        set_cfg(96, 48, 640, 16, 1, 1, 2, 1);
        do_reset();
        h0 = int'(Count_h);
        for (int i = 0; i < 10; i++) begin
            Pix_en = ~Pix_en;
            step();
        end
        check("half_rate_advance", int'(Count_h) - h0, 5);
        lows = 0; pulses = 0;
        for (int i = 0; i < 1600; i++) begin
            Pix_en = ~Pix_en;
            step();
            lows += int'(HSync == 1'b0);
            pulses += int'(Line_start);
        end
        check("hsync_low_192", lows, 192);
        check("line_pulses_half_rate", pulses, 1);

        // reset mid-line
        Pix_en = 1'b1;
        step(50);
        Rst = 1'b1;
        step();
        check("midrst_count_h", Count_h, 0);
        check("midrst_count_v", Count_v, 0);
        check("midrst_hsync", HSync, 1);
        check("midrst_h_left", H_left_margin, 0);
        Rst = 1'b0;
        step();
        check("postrst_h_left", H_left_margin, 144);
        check("postrst_count_h", Count_h, 1);
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
